// File: rtl/seq_sub_pkg.sv
// Shared types and constants for the sequential exponent subtractor.
package seq_sub_pkg;

    localparam int CHUNK = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        NEG  = 2'd2,
        DONE = 2'd3
    } seq_sub_state_t;

    // Chunk counter width; at least one bit even for a single-chunk operand.
    function automatic int cnt_w(input int width);
        return ((width / CHUNK) > 1) ? $clog2(width / CHUNK) : 1;
    endfunction

endpackage

// File: rtl/seq_exp_subtractor_cla3_chunk.sv
// 3-bit carry-lookahead adder slice shared by the subtract and negate passes.
module cla3_chunk (
    input  logic [2:0] x,
    input  logic [2:0] y,
    input  logic       ci,
    output logic [2:0] s,
    output logic       co
);
    logic [2:0] w_g;
    logic [2:0] w_p;
    logic       w_c1;
    logic       w_c2;

    assign w_g  = x & y;
    assign w_p  = x ^ y;
    assign w_c1 = w_g[0] | (w_p[0] & ci);
    assign w_c2 = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & ci);
    assign co   = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & ci);
    assign s    = w_p ^ {w_c2, w_c1, ci};

endmodule

// File: rtl/seq_exp_subtractor.sv
// Multi-cycle A - B exponent subtractor, 3 bits per cycle LSB-first.
// Define SEQ_SUB_ABS_EN to return |A - B| (adds the NEG pass).
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | one 3-bit chunk of a + ~b + carry per cycle
// NEG   | two's-complement negate of diff, chunk-wise (ABS build only)
// DONE  | result held with out_valid until out_ready
module seq_exp_subtractor
    import seq_sub_pkg::*;
#(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero
);
    localparam int N  = WIDTH / CHUNK;
    localparam int KW = cnt_w(WIDTH);
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    seq_sub_state_t r_state;
    seq_sub_state_t w_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_nb;
    logic [WIDTH-1:0] r_diff;
    logic [KW-1:0]    r_k;
    logic             r_carry;
    logic             r_borrow;
    logic             r_zero;

    logic [2:0]       w_x;
    logic [2:0]       w_y;
    logic [2:0]       w_s;
    logic             w_co;
    logic             w_last;
    logic [WIDTH-1:0] w_diff_nxt;

    assign w_last = (r_k == K_LAST);

    // One adder serves both passes: RUN adds a + ~b, NEG adds ~diff + 0.
    always_comb begin
        w_x = r_a[r_k*CHUNK +: CHUNK];
        w_y = r_nb[r_k*CHUNK +: CHUNK];
`ifdef SEQ_SUB_ABS_EN
        if (r_state == NEG) begin
            w_x = ~r_diff[r_k*CHUNK +: CHUNK];
            w_y = '0;
        end
`endif
        w_diff_nxt = r_diff;
        w_diff_nxt[r_k*CHUNK +: CHUNK] = w_s;
    end

    cla3_chunk u_cla (
        .x  (w_x),
        .y  (w_y),
        .ci (r_carry),
        .s  (w_s),
        .co (w_co)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (in_valid) w_next = RUN;
            RUN: begin
                if (w_last) begin
`ifdef SEQ_SUB_ABS_EN
                    w_next = w_co ? DONE : NEG;
`else
                    w_next = DONE;
`endif
                end
            end
`ifdef SEQ_SUB_ABS_EN
            NEG:  if (w_last) w_next = DONE;
`endif
            DONE: if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_nb     <= '0;
            r_diff   <= '0;
            r_k      <= '0;
            r_carry  <= 1'b0;
            r_borrow <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_nb    <= ~b;
                        r_carry <= 1'b1;
                        r_k     <= '0;
                    end
                end
                RUN: begin
                    r_diff  <= w_diff_nxt;
                    r_carry <= w_co;
                    r_k     <= r_k + KW'(1);
                    if (w_last) begin
                        r_borrow <= ~w_co;
                        r_zero   <= (w_diff_nxt == '0);
                        // Re-arm for the negate pass; harmless when going to DONE.
                        r_k      <= '0;
                        r_carry  <= 1'b1;
                    end
                end
`ifdef SEQ_SUB_ABS_EN
                NEG: begin
                    r_diff  <= w_diff_nxt;
                    r_carry <= w_co;
                    r_k     <= w_last ? '0 : r_k + KW'(1);
                end
`endif
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign diff      = r_diff;
    assign borrow    = r_borrow;
    assign zero      = r_zero;

endmodule

// File: doc/seq_exp_subtractor.md
# seq_exp_subtractor

Multi-cycle exponent subtractor for the floating-point datapath: computes A − B on WIDTH-bit unsigned operands, 3 bits per cycle LSB-first, using a 3-bit carry-lookahead chunk as A + ~B + 1. It sits ahead of the mantissa alignment shifter and supplies the exponent difference, borrow (A < B) and zero flags. Operands and results move over valid/ready handshakes on both sides.

## Interface
- WIDTH, default 9: operand/result width in bits; must be a multiple of 3, minimum 3.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands; high only in IDLE.
- a  in  WIDTH  minuend.
- b  in  WIDTH  subtrahend.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts result.
- diff  out  WIDTH  (a − b) mod 2^WIDTH, or |a − b| with SEQ_SUB_ABS_EN.
- borrow  out  1  1 when a < b.
- zero  out  1  1 when a == b.

## Operation
- States: IDLE, RUN, NEG (only with SEQ_SUB_ABS_EN), DONE.
- IDLE: in_ready=1. On in_valid && in_ready, latch a and ~b, set carry=1, chunk counter k=0, go to RUN.
- RUN: each cycle, add chunk k of a and ~b plus carry; write the 3-bit sum into diff[3k+2:3k]; register carry-out. k increments. After chunk N−1 (N=WIDTH/3): borrow = ~carry-out, zero = (diff==0), go to DONE. With ABS_EN and borrow=1, go to NEG instead.
- NEG: two's-complement negation of diff, chunk-wise LSB-first: chunk = ~chunk + carry with carry=1 at k=0, N cycles, then DONE. borrow stays 1. zero cannot be 1 here.
- DONE: out_valid=1; diff, borrow and zero are stable. On out_ready, go to IDLE. in_ready=0, so no new accept is possible in the same cycle.
- Arithmetic: all modulo 2^WIDTH. Carry chain is 3-bit lookahead inside a chunk and registered between chunks.
- Reset (including mid-RUN/NEG/DONE): state=IDLE, out_valid=0, diff=0, borrow=0, zero=0, k=0, carry=0. The in-flight operation is discarded. in_ready=1 in the first cycle after reset deasserts.

## Timing
- Accept edge T. Chunks are computed at edges T+1..T+N. out_valid is high from after edge T+N.
- Latency from accept to out_valid is N cycles (3 for WIDTH=9). With ABS_EN and a<b it is 2N.
- Throughput: at most one operation per N+2 cycles (accept, N chunks, one DONE handshake cycle minimum).
- Result fields change only on state transitions into DONE or on reset. They are never updated while out_valid=1.
- in_valid while busy is ignored (no accept). Upstream must hold its operands until in_ready.

## Configuration
- SEQ_SUB_ABS_EN defined: NEG state compiled in; diff is |a − b|, and borrow gives the sign.
- SEQ_SUB_ABS_EN undefined: there is no NEG state; diff is the raw modulo difference. Latency is always N.

## Structure
- Package seq_sub_pkg holds:
  - state enum (IDLE, RUN, NEG, DONE);
  - CHUNK=3 constant;
  - helper function for counter width, $clog2(WIDTH/CHUNK).
- One sub-module, cla3_chunk: combinational 3-bit lookahead adder with ports x[2:0], y[2:0], ci, s[2:0], co. It is instantiated once and reused by RUN and NEG through operand muxing.
- Top module holds the FSM, chunk counter, carry register and result register.

## Test plan
- WIDTH=9, a=300, b=45 -> after 3 cycles: diff=255, borrow=0, zero=0.
- a=45, b=300:
  - without ABS_EN -> diff=257, borrow=1 at 3 cycles;
  - with ABS_EN -> diff=255, borrow=1 at 6 cycles.
- a=b=170 -> diff=0, zero=1, borrow=0. Boundary case a=0, b=1 -> diff=511 (no ABS) / 1 (ABS), borrow=1.
- Backpressure: hold out_ready=0 for 10 cycles -> out_valid and diff remain stable, in_ready=0, and in_valid pulses are ignored. out_ready=1 -> IDLE next cycle.
- Assert rst during the 2nd RUN cycle -> next cycle out_valid=0, diff=0, in_ready=1. A new operation (a=7, b=2) then gives diff=5 with normal latency.
- Random 1000 pairs, out_ready randomized -> every result matches reference modulo/abs arithmetic.
